regfile_write_arbiter: RTL

- Shares the single register-file write port between the CPU writeback stage and four peripheral event sources (button, screen, collision, pause).
- Each source is a fixed-target special register.
- Latches single-cycle peripheral events, arbitrates them against CPU writebacks with a starvation guard, and drives a registered write port into the register file.
- Sits between the writeback stage, the peripheral I/O glue, and the register file.

---
 rtl/regfile_write_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port between CPU writeback and peripheral events
module regfile_write_arbiter #(
    parameter int         NUM_SRC  = 4,
    parameter int         MAX_WAIT = 3,
    parameter logic [4:0] SRC0_REG = 5'd20,
    parameter logic [4:0] SRC1_REG = 5'd22,
    parameter logic [4:0] SRC2_REG = 5'd24,
    parameter logic [4:0] SRC3_REG = 5'd26
) (
    input  logic                    clock,
    input  logic                    ctrl_reset_n,
    input  logic                    cpu_we,
    input  logic [4:0]              cpu_reg,
    input  logic [31:0]             cpu_data,
    output logic                    cpu_stall,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [32*NUM_SRC-1:0]   src_data,
    output logic [NUM_SRC-1:0]      src_ack,
    input  logic                    ovf_clear,
    output logic [NUM_SRC-1:0]      src_overflow,
    output logic [NUM_SRC-1:0]      pending,
    output logic                    ctrl_writeEnable,
    output logic [4:0]              ctrl_writeReg,
    output logic [31:0]             data_writeReg
);
    localparam int PW = $clog2(NUM_SRC);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [NUM_SRC-1:0]    pend_q;
    logic [32*NUM_SRC-1:0] data_q;
    logic [PW-1:0]         rr_ptr;
    logic [WW-1:0]         wait_cnt;

    logic                  cpu_valid;
    logic                  any_pend;
    logic                  force_periph;
    logic                  cpu_win;
    logic                  periph_win;
    logic                  found;
    logic [PW-1:0]         idx;
    logic [PW-1:0]         gnt_idx;
    logic [NUM_SRC-1:0]    grant;
    logic [NUM_SRC-1:0]    ovf_set;

    function automatic logic [4:0] target_reg(input logic [PW-1:0] sel);
        case (sel)
            PW'(0):  target_reg = SRC0_REG;
            PW'(1):  target_reg = SRC1_REG;
            PW'(2):  target_reg = SRC2_REG;
            default: target_reg = SRC3_REG;
        endcase
    endfunction

    // Writes to r0 are swallowed: never stalled, never written, never counted as a CPU win.
    always_comb begin
        cpu_valid    = cpu_we && (cpu_reg != 5'd0);
        any_pend     = |pend_q;
        force_periph = (wait_cnt == WW'(MAX_WAIT)) && any_pend;
        cpu_win      = cpu_valid && !force_periph;
        periph_win   = !cpu_win && any_pend;

        found   = 1'b0;
        idx     = '0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = rr_ptr + PW'(k);
            if (!found && pend_q[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end

        grant     = periph_win ? (NUM_SRC'(1) << gnt_idx) : '0;
        ovf_set   = src_valid & pend_q & ~grant;
        cpu_stall = ctrl_reset_n && cpu_valid && periph_win;
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            pend_q           <= '0;
            data_q           <= '0;
            src_overflow     <= '0;
            rr_ptr           <= '0;
            wait_cnt         <= '0;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= 5'd0;
            data_writeReg    <= 32'd0;
            src_ack          <= '0;
        end else begin
            // A new event landing on its own grant cycle simply re-arms the entry.
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid[i]) begin
                    pend_q[i]          <= 1'b1;
                    data_q[32*i +: 32] <= src_data[32*i +: 32];
                end else if (grant[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end

            if (ovf_clear) begin
                src_overflow <= '0;
            end else begin
                src_overflow <= src_overflow | ovf_set;
            end

            if (periph_win || !any_pend) begin
                wait_cnt <= '0;
            end else if (cpu_win) begin
                wait_cnt <= wait_cnt + WW'(1);
            end

            if (periph_win) begin
                rr_ptr <= gnt_idx + PW'(1);
            end

            ctrl_writeEnable <= cpu_win || periph_win;
            src_ack          <= grant;
            if (cpu_win) begin
                ctrl_writeReg <= cpu_reg;
                data_writeReg <= cpu_data;
            end else if (periph_win) begin
                ctrl_writeReg <= target_reg(gnt_idx);
                data_writeReg <= data_q[32*int'(gnt_idx) +: 32];
            end
        end
    end

    assign pending = pend_q;

endmodule
